// File: rtl/sparc_exu_div_yreg_ctl.sv
// rtl/sparc_exu_div_yreg_ctl.sv - Y-register file control: WRY staging, MUL/MULScc selects, RDY stall
// Optional: YREG_CTL_COLLIDE_CHK_EN enables the sticky yctl_err checker.
module sparc_exu_div_yreg_ctl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ecl_thr_m,
    input  logic       ecl_wry_m,
    input  logic       ecl_muls_m,
    input  logic       ecl_muls_rs1_0_m,
    input  logic       ecl_flush_w,
    input  logic [3:0] ecl_thr_e,
    input  logic       ecl_rdy_e,
    input  logic       ecl_mul_issue_e,
    input  logic       mul_yreg_vld_g,
    input  logic [3:0] mul_thr_g,
    output logic [3:0] ecl_div_yreg_wen_w,
    output logic [3:0] ecl_div_yreg_wen_g,
    output logic [3:0] ecl_div_yreg_wen_l,
    output logic [3:0] ecl_div_yreg_shift_g,
    output logic       ecl_div_yreg_data_31_g,
    output logic       yctl_rdy_stall_e,
    output logic [3:0] yctl_mul_rdy,
    output logic       yctl_err
);

    localparam int         NTHR     = 4;
    localparam logic [1:0] MUL_MAXP = 2'd2;

    logic                 w_vld;
    logic [NTHR-1:0]      w_thr;
    logic                 w2_vld;
    logic [NTHR-1:0]      w2_thr;
    logic                 g_vld;
    logic [NTHR-1:0]      g_thr;
    logic                 g_d31;
    logic [NTHR-1:0][1:0] cnt;
    logic [NTHR-1:0][1:0] cnt_nxt;

    logic [NTHR-1:0] wry_sel;
    logic [NTHR-1:0] mul_sel;
    logic [NTHR-1:0] sft_sel;
    logic [NTHR-1:0] blk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_vld  <= 1'b0;
            w_thr  <= '0;
            w2_vld <= 1'b0;
            w2_thr <= '0;
            g_vld  <= 1'b0;
            g_thr  <= '0;
            g_d31  <= 1'b0;
            cnt    <= '0;
        end else begin
            w_vld  <= ecl_wry_m;
            w_thr  <= ecl_thr_m;
            // A flush in W kills the WRY before it reaches the W2 select
            w2_vld <= w_vld & ~ecl_flush_w;
            w2_thr <= w_thr;
            g_vld  <= ecl_muls_m;
            g_thr  <= ecl_thr_m;
            g_d31  <= ecl_muls_rs1_0_m;
            cnt    <= cnt_nxt;
        end
    end

    assign wry_sel = {NTHR{w2_vld}} & w2_thr;
    assign mul_sel = {NTHR{mul_yreg_vld_g}} & mul_thr_g;
    assign sft_sel = {NTHR{g_vld}} & g_thr;

    // mux4ds needs exactly one select per thread: WRY beats MUL beats MULScc
    assign ecl_div_yreg_wen_w     = wry_sel;
    assign ecl_div_yreg_wen_g     = mul_sel & ~wry_sel;
    assign ecl_div_yreg_shift_g   = sft_sel & ~wry_sel & ~mul_sel;
    assign ecl_div_yreg_wen_l     = ~(wry_sel | mul_sel | sft_sel);
    assign ecl_div_yreg_data_31_g = g_d31;

    always_comb begin
        cnt_nxt      = cnt;
        yctl_mul_rdy = '0;
        blk          = '0;
        for (int t = 0; t < NTHR; t++) begin
            case ({ecl_mul_issue_e & ecl_thr_e[t], mul_sel[t]})
                2'b10:   if (cnt[t] != MUL_MAXP) cnt_nxt[t] = cnt[t] + 2'd1;
                2'b01:   if (cnt[t] != 2'd0)     cnt_nxt[t] = cnt[t] - 2'd1;
                default: cnt_nxt[t] = cnt[t];
            endcase
            yctl_mul_rdy[t] = (cnt[t] < MUL_MAXP);
            blk[t] = (cnt[t] != 2'd0) | (w_vld & w_thr[t]) | (w2_vld & w2_thr[t]) | sft_sel[t];
        end
    end

    assign yctl_rdy_stall_e = ecl_rdy_e & (|(ecl_thr_e & blk));

`ifdef YREG_CTL_COLLIDE_CHK_EN
    function automatic logic not_onehot(input logic [NTHR-1:0] v);
        return (v == '0) || ((v & (v - 1'b1)) != '0);
    endfunction

    logic            err_q;
    logic [NTHR-1:0] coll;
    logic [NTHR-1:0] ovf;
    logic [NTHR-1:0] unf;
    logic            bad_thr;

    always_comb begin
        coll = (wry_sel & mul_sel) | (wry_sel & sft_sel) | (mul_sel & sft_sel);
        ovf  = '0;
        unf  = '0;
        for (int t = 0; t < NTHR; t++) begin
            ovf[t] = ecl_mul_issue_e & ecl_thr_e[t] & ~mul_sel[t] & (cnt[t] == MUL_MAXP);
            unf[t] = mul_sel[t] & ~(ecl_mul_issue_e & ecl_thr_e[t]) & (cnt[t] == 2'd0);
        end
        bad_thr = ((ecl_wry_m | ecl_muls_m) & not_onehot(ecl_thr_m))
                | ((ecl_rdy_e | ecl_mul_issue_e) & not_onehot(ecl_thr_e))
                | (mul_yreg_vld_g & not_onehot(mul_thr_g));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | (|coll) | (|ovf) | (|unf) | bad_thr;
    end

    assign yctl_err = err_q;
`else
    assign yctl_err = 1'b0;
`endif

endmodule

// File: tb/tb_sparc_exu_div_yreg_ctl.sv
// tb/tb_sparc_exu_div_yreg_ctl.sv - self-checking bench with cycle-history reference model
module tb_sparc_exu_div_yreg_ctl;

`ifdef YREG_CTL_COLLIDE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int HN = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ecl_thr_m = '0;
    logic       ecl_wry_m = 1'b0;
    logic       ecl_muls_m = 1'b0;
    logic       ecl_muls_rs1_0_m = 1'b0;
    logic       ecl_flush_w = 1'b0;
    logic [3:0] ecl_thr_e = '0;
    logic       ecl_rdy_e = 1'b0;
    logic       ecl_mul_issue_e = 1'b0;
    logic       mul_yreg_vld_g = 1'b0;
    logic [3:0] mul_thr_g = '0;
    logic [3:0] wen_w, wen_g, wen_l, shift_g, mul_rdy;
    logic       data_31, stall, err;

    sparc_exu_div_yreg_ctl dut (
        .clk(clk), .rst(rst),
        .ecl_thr_m(ecl_thr_m), .ecl_wry_m(ecl_wry_m), .ecl_muls_m(ecl_muls_m),
        .ecl_muls_rs1_0_m(ecl_muls_rs1_0_m), .ecl_flush_w(ecl_flush_w),
        .ecl_thr_e(ecl_thr_e), .ecl_rdy_e(ecl_rdy_e), .ecl_mul_issue_e(ecl_mul_issue_e),
        .mul_yreg_vld_g(mul_yreg_vld_g), .mul_thr_g(mul_thr_g),
        .ecl_div_yreg_wen_w(wen_w), .ecl_div_yreg_wen_g(wen_g),
        .ecl_div_yreg_wen_l(wen_l), .ecl_div_yreg_shift_g(shift_g),
        .ecl_div_yreg_data_31_g(data_31), .yctl_rdy_stall_e(stall),
        .yctl_mul_rdy(mul_rdy), .yctl_err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-cycle input history plus per-thread MUL counts
    int         cyc  = 0;
    int         base = 0;
    logic [3:0] h_thrm [HN];
    bit         h_wry  [HN];
    bit         h_muls [HN];
    bit         h_rs1  [HN];
    bit         h_flush[HN];
    int         cnt_m[4];
    bit         err_m;
    bit         coll_now;

    logic [3:0] x_wen_w, x_wen_g, x_wen_l, x_shift, x_rdy;
    logic       x_d31, x_stall, x_err;

    function automatic bit ok(int i);
        return i >= base;
    endfunction

    function automatic bit not_onehot(logic [3:0] v);
        return $countones(v) != 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ecl_thr_m = '0; ecl_wry_m = 0; ecl_muls_m = 0; ecl_muls_rs1_0_m = 0; ecl_flush_w = 0;
        ecl_thr_e = '0; ecl_rdy_e = 0; ecl_mul_issue_e = 0; mul_yreg_vld_g = 0; mul_thr_g = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = cyc;
        for (int t = 0; t < 4; t++) cnt_m[t] = 0;
        err_m = 0;
    endtask

    task automatic drive(input logic [3:0] thr_m, input bit wry, input bit muls, input bit rs1,
                         input bit flush, input logic [3:0] thr_e, input bit rdy, input bit issue,
                         input bit mvld, input logic [3:0] mthr);
        logic [3:0] w_raw, g_raw, s_raw;
        bit         w2_live;
        ecl_thr_m = thr_m; ecl_wry_m = wry; ecl_muls_m = muls; ecl_muls_rs1_0_m = rs1;
        ecl_flush_w = flush; ecl_thr_e = thr_e; ecl_rdy_e = rdy; ecl_mul_issue_e = issue;
        mul_yreg_vld_g = mvld; mul_thr_g = mthr;
        h_thrm[cyc] = thr_m; h_wry[cyc] = wry; h_muls[cyc] = muls;
        h_rs1[cyc] = rs1; h_flush[cyc] = flush;

        w2_live = ok(cyc - 2) && h_wry[cyc-2] && !h_flush[cyc-1];
        w_raw   = w2_live ? h_thrm[cyc-2] : 4'h0;
        s_raw   = (ok(cyc - 1) && h_muls[cyc-1]) ? h_thrm[cyc-1] : 4'h0;
        g_raw   = mvld ? mthr : 4'h0;
        x_wen_w = w_raw;
        x_wen_g = g_raw & ~w_raw;
        x_shift = s_raw & ~w_raw & ~g_raw;
        x_wen_l = ~(w_raw | g_raw | s_raw);
        x_d31   = ok(cyc - 1) ? h_rs1[cyc-1] : 1'b0;
        x_stall = 1'b0;
        for (int t = 0; t < 4; t++) begin
            x_rdy[t] = cnt_m[t] < 2;
            if (rdy && thr_e[t] &&
                (cnt_m[t] != 0 || s_raw[t] || w_raw[t] ||
                 (ok(cyc - 1) && h_wry[cyc-1] && h_thrm[cyc-1][t])))
                x_stall = 1'b1;
        end
        x_err    = CHK & err_m;
        coll_now = ((w_raw & g_raw) | (w_raw & s_raw) | (g_raw & s_raw)) != 4'h0;
        @(negedge clk);
    endtask

    task automatic tick();
        bit inc, dec;
        if (coll_now) err_m = 1;
        if ((ecl_wry_m || ecl_muls_m) && not_onehot(ecl_thr_m)) err_m = 1;
        if ((ecl_rdy_e || ecl_mul_issue_e) && not_onehot(ecl_thr_e)) err_m = 1;
        if (mul_yreg_vld_g && not_onehot(mul_thr_g)) err_m = 1;
        for (int t = 0; t < 4; t++) begin
            inc = ecl_mul_issue_e && ecl_thr_e[t];
            dec = mul_yreg_vld_g && mul_thr_g[t];
            if (inc && !dec) begin
                if (cnt_m[t] == 2) err_m = 1; else cnt_m[t]++;
            end else if (dec && !inc) begin
                if (cnt_m[t] == 0) err_m = 1; else cnt_m[t]--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        drive(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        total++;
        if ({wen_w, wen_g, wen_l, shift_g, data_31, stall, mul_rdy, err} !== {4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0}) begin
            bad++;
            $display("FAIL reset got=%h_%h_%h_%h_%b_%b_%h_%b exp=0_0_f_0_0_0_f_0",
                     wen_w, wen_g, wen_l, shift_g, data_31, stall, mul_rdy, err);
        end
        tick();
    endtask

    task automatic test_wry();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(4'b0100, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
            else idle();
            total++;
            if (wen_w !== ((i == 2) ? 4'b0100 : 4'b0000) || wen_l !== ((i == 2) ? 4'b1011 : 4'b1111)) begin
                bad++;
                $display("FAIL wry cyc%0d wen_w=%b wen_l=%b exp_w2=%0d", i, wen_w, wen_l, i == 2);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(4'b0010, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
                1: drive(4'h0, 0, 0, 0, 1, 4'b0010, 1, 0, 0, 4'h0);
                default: drive(4'h0, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 4'h0);
            endcase
            total++;
            if (wen_w !== 4'h0) begin
                bad++;
                $display("FAIL flush_wen cyc%0d got=%b exp=0000", i, wen_w);
            end
            if (i == 1 || i == 3) begin
                total++;
                if (stall !== (i == 1)) begin
                    bad++;
                    $display("FAIL flush_stall cyc%0d got=%b exp=%b", i, stall, i == 1);
                end
            end
            tick();
        end
    endtask

    task automatic test_muls();
        do_reset();
        drive(4'b0001, 0, 1, 1, 0, 4'h0, 0, 0, 0, 4'h0);
        tick();
        idle();
        total++;
        if (shift_g !== 4'b0001 || data_31 !== 1'b1 || wen_l !== 4'b1110) begin
            bad++;
            $display("FAIL muls got shift=%b d31=%b wen_l=%b exp 0001/1/1110", shift_g, data_31, wen_l);
        end
        tick();
        idle();
        total++;
        if (shift_g !== 4'b0000) begin
            bad++;
            $display("FAIL muls_once got=%b exp=0000", shift_g);
        end
        tick();
    endtask

    task automatic test_mul_cnt();
        logic [3:0] e_rdy [6];
        bit         e_stl [6];
        e_rdy = '{4'hF, 4'hF, 4'h7, 4'h7, 4'hF, 4'hF};
        e_stl = '{0, 0, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1:    drive(4'h0, 0, 0, 0, 0, 4'b1000, 0, 1, 0, 4'h0);
                2:       drive(4'h0, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 4'h0);
                3, 4:    drive(4'h0, 0, 0, 0, 0, 4'b1000, 1, 0, 1, 4'b1000);
                default: drive(4'h0, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 4'h0);
            endcase
            total++;
            if (mul_rdy !== e_rdy[i] || stall !== e_stl[i]) begin
                bad++;
                $display("FAIL mul_cnt cyc%0d rdy=%b stall=%b exp rdy=%b stall=%b", i, mul_rdy, stall, e_rdy[i], e_stl[i]);
            end
            if (i >= 3 && i <= 4) begin
                total++;
                if (wen_g !== 4'b1000) begin
                    bad++;
                    $display("FAIL mul_weng cyc%0d got=%b exp=1000", i, wen_g);
                end
            end
            tick();
        end
    endtask

    task automatic test_collide();
        do_reset();
        drive(4'b0001, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0); tick();
        drive(4'b0001, 0, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0); tick();
        drive(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 4'b0001);
        total++;
        if ({wen_w, wen_g, shift_g, wen_l} !== {4'b0001, 4'b0000, 4'b0000, 4'b1110}) begin
            bad++;
            $display("FAIL collide w=%b g=%b s=%b l=%b exp 0001/0000/0000/1110", wen_w, wen_g, shift_g, wen_l);
        end
        tick();
        idle();
        total++;
        if (err !== CHK) begin
            bad++;
            $display("FAIL collide_err got=%b exp=%b", err, CHK);
        end
        tick();
    endtask

    task automatic test_cross();
        do_reset();
        drive(4'b0001, 1, 0, 0, 0, 4'b0010, 0, 1, 0, 4'h0); tick();
        drive(4'b0100, 0, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0); tick();
        drive(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 4'b0010);
        total++;
        if ({wen_w, wen_g, shift_g, wen_l} !== {4'b0001, 4'b0010, 4'b0100, 4'b1000}) begin
            bad++;
            $display("FAIL cross w=%b g=%b s=%b l=%b exp 0001/0010/0100/1000", wen_w, wen_g, shift_g, wen_l);
        end
        tick();
        idle();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL cross_err got=%b exp=0", err);
        end
        tick();
    endtask

    function automatic logic [3:0] rnd_thr();
        if ($urandom_range(0, 15) == 0) return 4'($urandom_range(0, 15));
        return 4'b0001 << $urandom_range(0, 3);
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) begin
                drive(rnd_thr(), 1, 1, 1, 0, rnd_thr(), 0, 1, 0, 4'h0);
                do_reset();
            end
            drive(rnd_thr(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
                  $urandom_range(0, 3) == 0, rnd_thr(), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, rnd_thr());
            total++;
            if ({wen_w, wen_g, wen_l, shift_g, data_31, stall, mul_rdy, err} !==
                {x_wen_w, x_wen_g, x_wen_l, x_shift, x_d31, x_stall, x_rdy, x_err}) begin
                bad++;
                $display("FAIL random cyc%0d got=%b_%b_%b_%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b_%b_%b_%b", i,
                         wen_w, wen_g, wen_l, shift_g, data_31, stall, mul_rdy, err,
                         x_wen_w, x_wen_g, x_wen_l, x_shift, x_d31, x_stall, x_rdy, x_err);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_wry();
        test_flush();
        test_muls();
        test_mul_cnt();
        test_collide();
        test_cross();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
